// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared state encoding and occupancy helpers for the skid stage
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int COUNT_W = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   function automatic logic [COUNT_W-1:0] state_count(input state_e st);
      case (st)
         ST_ONE:  state_count = COUNT_W'(1);
         ST_FULL: state_count = COUNT_W'(2);
         default: state_count = COUNT_W'(0);
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_data_reg.sv
// ============================================================================
// Module   : pipe_data_reg
// Brief    : Payload register with load enable and synchronous clear to bubble
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_data_reg #(
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] data_q;

   // Clear wins over load so a flush never lets a new payload slip in.
   always_comb begin
      data_d = data_q;
      if (i_clr) begin
         data_d = BUBBLE_VAL;
      end else if (i_load) begin
         data_d = i_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         data_q <= BUBBLE_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign o_q = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Two-entry skid buffer stage with registered ready, stall and flush
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_flush,
   input  logic               i_stall,
   input  logic               i_up_valid,
   output logic               o_up_ready,
   input  logic [DATA_W-1:0]  i_up_data,
   output logic               o_dn_valid,
   input  logic               i_dn_ready,
   output logic [DATA_W-1:0]  o_dn_data,
   output logic [COUNT_W-1:0] o_count
);

   state_e               state_d, state_q;
   logic                 up_ready_d, up_ready_q;
   logic                 dn_valid_d, dn_valid_q;
   logic [COUNT_W-1:0]   count_d, count_q;

   logic                 up_xfer;
   logic                 dn_xfer;
   logic                 main_load, main_clr, main_sel_skid;
   logic                 skid_load, skid_clr;
   logic [DATA_W-1:0]    main_d;
   logic [DATA_W-1:0]    main_q;
   logic [DATA_W-1:0]    skid_q;

   assign up_xfer = i_up_valid & up_ready_q;
   assign dn_xfer = dn_valid_q & i_dn_ready & ~i_stall;

   always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      main_clr      = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (i_flush) begin
         state_d  = ST_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (up_xfer) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (up_xfer && dn_xfer) begin
                  main_load = 1'b1;
               end else if (up_xfer) begin
                  state_d   = ST_FULL;
                  skid_load = 1'b1;
               end else if (dn_xfer) begin
                  // Clearing MAIN keeps the bubble value on the output while empty.
                  state_d  = ST_EMPTY;
                  main_clr = 1'b1;
               end
            end
            ST_FULL: begin
               if (dn_xfer) begin
                  state_d       = ST_ONE;
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_clr      = 1'b1;
               end
            end
            default: begin
               state_d  = ST_EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   assign main_d     = main_sel_skid ? skid_q : i_up_data;
   // Status outputs come straight from flops so ready has no input-to-output path.
   assign up_ready_d = (state_d != ST_FULL);
   assign dn_valid_d = (state_d != ST_EMPTY);
   assign count_d    = state_count(state_d);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_EMPTY;
         up_ready_q <= 1'b1;
         dn_valid_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         up_ready_q <= up_ready_d;
         dn_valid_q <= dn_valid_d;
         count_q    <= count_d;
      end
   end

   pipe_data_reg #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
   ) u_main (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (main_clr),
      .i_load    (main_load),
      .i_d       (main_d),
      .o_q       (main_q)
   );

   pipe_data_reg #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
   ) u_skid (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (skid_clr),
      .i_load    (skid_load),
      .i_d       (i_up_data),
      .o_q       (skid_q)
   );

   assign o_up_ready = up_ready_q;
   assign o_dn_valid = dn_valid_q;
   assign o_dn_data  = main_q;
   assign o_count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Directed self-checking bench for pipe_skid_stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

   localparam int DATA_W = 32;

   logic              clk;
   logic              reset_n;
   logic              flush;
   logic              stall;
   logic              up_valid;
   logic              up_ready;
   logic [DATA_W-1:0] up_data;
   logic              dn_valid;
   logic              dn_ready;
   logic [DATA_W-1:0] dn_data;
   logic [1:0]        count;

   int errors = 0;
   int checks = 0;

   pipe_skid_stage #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL ('0)
   ) dut (
      .i_clk      (clk),
      .i_reset_n  (reset_n),
      .i_flush    (flush),
      .i_stall    (stall),
      .i_up_valid (up_valid),
      .o_up_ready (up_ready),
      .i_up_data  (up_data),
      .o_dn_valid (dn_valid),
      .i_dn_ready (dn_ready),
      .o_dn_data  (dn_data),
      .o_count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush    = 1'b0;
      stall    = 1'b0;
      up_valid = 1'b0;
      up_data  = '0;
      dn_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      checks++; if (dn_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%0b exp=0", dn_valid); end
      checks++; if (dn_data !== 32'h0)  begin errors++; $display("FAIL reset_data got=%h exp=0", dn_data); end
      checks++; if (up_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got=%0b exp=1", up_ready); end
      checks++; if (count !== 2'd0)     begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      up_valid = 1'b1; up_data = 32'hA5;
      step();
      up_valid = 1'b0; up_data = '0;
      checks++; if (dn_valid !== 1'b1)           begin errors++; $display("FAIL single_valid got=%0b exp=1", dn_valid); end
      checks++; if (dn_data !== 32'h0000_00A5)   begin errors++; $display("FAIL single_data got=%h exp=000000a5", dn_data); end
      checks++; if (count !== 2'd1)              begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
      dn_ready = 1'b1;
      step();
      checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || count !== 2'd0)
         begin errors++; $display("FAIL single_drain got v=%0b d=%h c=%0d exp v=0 d=0 c=0", dn_valid, dn_data, count); end
      dn_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      dn_ready = 1'b0;
      up_valid = 1'b1; up_data = 32'h11;
      step();
      checks++; if (count !== 2'd1 || up_ready !== 1'b1)
         begin errors++; $display("FAIL bp_first got c=%0d r=%0b exp c=1 r=1", count, up_ready); end
      up_data = 32'h22;
      step();
      up_valid = 1'b0; up_data = '0;
      checks++; if (count !== 2'd2)     begin errors++; $display("FAIL bp_count got=%0d exp=2", count); end
      checks++; if (up_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready got=%0b exp=0", up_ready); end
      checks++; if (dn_data !== 32'h11 || dn_valid !== 1'b1)
         begin errors++; $display("FAIL bp_head got v=%0b d=%h exp v=1 d=11", dn_valid, dn_data); end
      step();
      checks++; if (dn_data !== 32'h11) begin errors++; $display("FAIL bp_hold got=%h exp=11", dn_data); end
      dn_ready = 1'b1;
      step();
      checks++; if (dn_valid !== 1'b1 || dn_data !== 32'h22 || count !== 2'd1 || up_ready !== 1'b1)
         begin errors++; $display("FAIL bp_second got v=%0b d=%h c=%0d r=%0b exp v=1 d=22 c=1 r=1", dn_valid, dn_data, count, up_ready); end
      step();
      checks++; if (dn_valid !== 1'b0 || count !== 2'd0)
         begin errors++; $display("FAIL bp_empty got v=%0b c=%0d exp v=0 c=0", dn_valid, count); end
      dn_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int bad_data  = 0;
      int bad_ready = 0;
      dn_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         checks++; if (up_ready !== 1'b1) begin errors++; bad_ready++;
            $display("FAIL b2b_ready idx=%0d got=%0b exp=1", i, up_ready); end
         up_valid = 1'b1; up_data = i;
         step();
         checks++; if (dn_valid !== 1'b1 || dn_data !== 32'(i)) begin errors++; bad_data++;
            $display("FAIL b2b_data idx=%0d got v=%0b d=%0d exp v=1 d=%0d", i, dn_valid, dn_data, i); end
      end
      up_valid = 1'b0; up_data = '0;
      step();
      checks++; if (dn_valid !== 1'b0 || count !== 2'd0)
         begin errors++; $display("FAIL b2b_tail got v=%0b c=%0d exp v=0 c=0", dn_valid, count); end
      dn_ready = 1'b0;
   endtask

   task automatic test_flush();
      dn_ready = 1'b0;
      up_valid = 1'b1; up_data = 32'h55;
      step();
      up_data = 32'h66;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre got=%0d exp=2", count); end
      flush = 1'b1; up_valid = 1'b1; up_data = 32'h33; dn_ready = 1'b1;
      step();
      flush = 1'b0; up_valid = 1'b0; up_data = '0;
      checks++; if (dn_valid !== 1'b0)  begin errors++; $display("FAIL flush_valid got=%0b exp=0", dn_valid); end
      checks++; if (dn_data !== 32'h0)  begin errors++; $display("FAIL flush_data got=%h exp=0", dn_data); end
      checks++; if (count !== 2'd0)     begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
      checks++; if (up_ready !== 1'b1)  begin errors++; $display("FAIL flush_ready got=%0b exp=1", up_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (dn_valid !== 1'b0 || dn_data === 32'h33)
            begin errors++; $display("FAIL flush_leak cyc=%0d got v=%0b d=%h exp v=0", i, dn_valid, dn_data); end
      end
      dn_ready = 1'b0;
   endtask

   task automatic test_stall();
      dn_ready = 1'b1; stall = 1'b1;
      up_valid = 1'b1; up_data = 32'h44;
      step();
      up_valid = 1'b0; up_data = '0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (dn_valid !== 1'b1 || dn_data !== 32'h44 || count !== 2'd1)
            begin errors++; $display("FAIL stall_hold cyc=%0d got v=%0b d=%h c=%0d exp v=1 d=44 c=1", i, dn_valid, dn_data, count); end
      end
      up_valid = 1'b1; up_data = 32'h45;
      step();
      up_valid = 1'b0; up_data = '0;
      checks++; if (count !== 2'd2 || up_ready !== 1'b0 || dn_data !== 32'h44)
         begin errors++; $display("FAIL stall_fill got c=%0d r=%0b d=%h exp c=2 r=0 d=44", count, up_ready, dn_data); end
      stall = 1'b0;
      step();
      stall = 1'b1;
      checks++; if (dn_valid !== 1'b1 || dn_data !== 32'h45 || count !== 2'd1)
         begin errors++; $display("FAIL stall_release got v=%0b d=%h c=%0d exp v=1 d=45 c=1", dn_valid, dn_data, count); end
      step();
      checks++; if (dn_data !== 32'h45 || count !== 2'd1)
         begin errors++; $display("FAIL stall_single got d=%h c=%0d exp d=45 c=1", dn_data, count); end
      stall = 1'b0;
      step();
      checks++; if (dn_valid !== 1'b0 || count !== 2'd0)
         begin errors++; $display("FAIL stall_drain got v=%0b c=%0d exp v=0 c=0", dn_valid, count); end
      dn_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      dn_ready = 1'b0;
      up_valid = 1'b1; up_data = 32'h99;
      step();
      up_data = 32'hAA;
      step();
      up_valid = 1'b0; up_data = '0;
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL areset_pre got=%0d exp=2", count); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || up_ready !== 1'b1 || count !== 2'd0)
         begin errors++; $display("FAIL areset_clear got v=%0b d=%h r=%0b c=%0d exp v=0 d=0 r=1 c=0", dn_valid, dn_data, up_ready, count); end
      #1;
      reset_n = 1'b1;
      up_valid = 1'b1; up_data = 32'h77;
      step();
      up_valid = 1'b0; up_data = '0;
      checks++; if (dn_valid !== 1'b1 || dn_data !== 32'h77 || count !== 2'd1)
         begin errors++; $display("FAIL areset_post got v=%0b d=%h c=%0d exp v=1 d=77 c=1", dn_valid, dn_data, count); end
      dn_ready = 1'b1;
      step();
      checks++; if (dn_valid !== 1'b0 || dn_data === 32'hAA)
         begin errors++; $display("FAIL areset_stale got v=%0b d=%h exp v=0", dn_valid, dn_data); end
      dn_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_stall();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning payload width in bits (>=1).
REQ-002 SHALL provide parameter BUBBLE_VAL, default all-zero DATA_W, meaning payload value driven while the stage is empty or after flush/reset.
REQ-003 SHALL use reset i_reset_n, asynchronous, active-low; clock i_clk.
REQ-004 SHALL have ports, in order:
- i_clk  in  1  clock
- i_reset_n  in  1  async active-low reset
- i_flush  in  1  synchronous kill of all held entries
- i_stall  in  1  freeze downstream transfer; acts as i_dn_ready=0
- i_up_valid  in  1  upstream payload valid
- o_up_ready  out  1  stage can accept
- i_up_data  in  DATA_W  upstream payload
- o_dn_valid  out  1  downstream payload valid
- i_dn_ready  in  1  downstream can accept
- o_dn_data  out  DATA_W  downstream payload
- o_count  out  2  entries held (0..2)

Function
REQ-005 SHALL hold two entries: MAIN (drives o_dn_*) and SKID (overflow); states EMPTY (none), ONE (MAIN only), FULL (MAIN+SKID).
REQ-006 SHALL define up_xfer = i_up_valid & o_up_ready; dn_xfer = o_dn_valid & i_dn_ready & ~i_stall.
REQ-007 SHALL drive o_up_ready = ~SKID valid, from a register only; no combinational path from i_dn_ready, i_stall or i_up_valid to o_up_ready.
REQ-008 SHALL transition: EMPTY+up_xfer -> ONE, MAIN<=i_up_data.
REQ-009 SHALL transition: ONE+up_xfer+dn_xfer -> ONE, MAIN<=i_up_data; ONE+up_xfer only -> FULL, SKID<=i_up_data; ONE+dn_xfer only -> EMPTY.
REQ-010 SHALL transition: FULL+dn_xfer -> ONE, MAIN<=SKID; FULL without dn_xfer -> FULL, unchanged (no up_xfer possible).
REQ-011 SHALL deliver payloads in acceptance order, none duplicated or dropped.
REQ-012 SHALL have latency 1 cycle: payload accepted at edge N appears on o_dn_data after edge N when stage was EMPTY, or ONE with dn_xfer.
REQ-013 SHALL sustain 1 transfer/cycle while i_dn_ready=1 and i_stall=0.
REQ-014 SHALL hold o_dn_valid and o_dn_data stable while o_dn_valid=1 and no dn_xfer.
REQ-015 SHALL drive o_dn_data=BUBBLE_VAL whenever o_dn_valid=0.
REQ-016 SHALL give i_flush priority over i_stall and all transfers: next state EMPTY, both payloads<=BUBBLE_VAL, that cycle's up_xfer discarded, o_up_ready=1 next cycle.
REQ-017 SHALL treat i_stall=1 with i_dn_ready=1 as no dn_xfer; upstream acceptance continues until FULL.
REQ-018 SHALL drive o_count = 0/1/2 for EMPTY/ONE/FULL, registered.
REQ-019 SHALL never enter MAIN invalid with SKID valid.

Reset
REQ-020 SHALL on i_reset_n=0 asynchronously force EMPTY: o_dn_valid=0, o_dn_data=BUBBLE_VAL, SKID=BUBBLE_VAL, o_up_ready=1, o_count=0.
REQ-021 SHALL discard in-flight entries on reset mid-operation; first post-reset edge behaves as from EMPTY.

Structure
REQ-022 SHALL place the state enum typedef (EMPTY/ONE/FULL) and count-width constant in shared package pipe_pkg.
REQ-023 SHALL implement MAIN and SKID as two instances of sub-module pipe_data_reg (DATA_W register with load enable and synchronous clear to BUBBLE_VAL, async reset).

Verification
REQ-024 SHALL cover: reset, i_up_valid=1 data 0xA5 -> o_dn_valid=1, o_dn_data=0x000000A5 next cycle, o_count=1.
REQ-025 SHALL cover: i_dn_ready=0, push 0x11 then 0x22 -> o_count=2, o_up_ready=0, o_dn_data=0x11; release ready -> 0x11 then 0x22 on consecutive cycles.
REQ-026 SHALL cover: 100 back-to-back payloads 0..99, i_dn_ready=1 -> 100 outputs in order, 1/cycle, o_up_ready never low.
REQ-027 SHALL cover: FULL, then i_flush=1 with i_up_valid=1 data 0x33 -> next cycle o_dn_valid=0, o_dn_data=BUBBLE_VAL, o_count=0, 0x33 never emitted.
REQ-028 SHALL cover: i_stall=1, i_dn_ready=1 with valid 0x44 held -> o_dn_data stays 0x44, no dn_xfer; stall drop -> single transfer.
REQ-029 SHALL cover: assert i_reset_n=0 mid-cycle in FULL -> outputs cleared immediately without clock edge.
